ifetch_prefetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the single-cycle RV32 core.
//  - Replaces the bench-driven instr/pc path: owns the PC, issues word reads to an external

---
 rtl/ifetch_prefetch_unit.sv | 156 +++++++++++++++
 tb/tb_ifetch_prefetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_unit.sv
// rtl/ifetch_prefetch_unit.sv - instruction prefetch front end with redirect flush
//
// Purpose: owns the fetch PC, issues word reads to instruction memory, buffers
// returned words in a DEPTH-entry FIFO and presents {pc, instr} to the core.
// A redirect flushes the FIFO and discards every read still in flight.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   imem_req_o / imem_addr_o   read request and word-aligned address
//   imem_gnt_i                 request accepted this cycle
//   imem_rvalid_i/imem_rdata_i in-order read response
//   redirect_i/redirect_pc_i   flush and restart fetch at the given PC
//   instr_valid_o/instr_ready_i head handshake to the core
//   instr_o / pc_o             head instruction and its PC (zero when empty)
//   perf_stall_o/perf_flush_o  saturating counters, present only with IFETCH_PERF_EN
//
// Optional feature macro: IFETCH_PERF_EN
module ifetch_prefetch_unit #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_o,
  output logic [15:0]     perf_flush_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAXO_C  = CNT_W'(MAX_OUTST);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  // Kept responses always belong to the sequential run started at the last
  // redirect (or reset), so their PC tags are generated by a running counter.
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [XLEN-1:0]  pc_mem_q    [DEPTH];
  logic [XLEN-1:0]  instr_mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic             grant, rsp, push, pop;
  logic [XLEN-1:0]  redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc_i & ~XLEN'(3);

  // Space is reserved for every outstanding read, so a kept response always fits.
  assign imem_req_o = !rst && !redirect_i
                      && (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C)
                      && (outst_q < MAXO_C);
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = !rst && (count_q != '0);
  assign instr_o       = instr_valid_o ? instr_mem_q[rptr_q] : '0;
  assign pc_o          = instr_valid_o ? pc_mem_q[rptr_q]    : '0;

  assign grant = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp   = imem_rvalid_i && (outst_q != '0);
  assign push  = rsp && (discard_q == '0) && !redirect_i;
  assign pop   = instr_valid_o && instr_ready_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    discard_d  = discard_q;
    outst_d    = outst_q + CNT_W'(grant) - CNT_W'(rsp);
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      // Everything still unreturned after this cycle belongs to the old stream.
      discard_d  = outst_q - CNT_W'(rsp);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
      if (push) begin
        wptr_d    = wptr_q + PTR_W'(1);
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
      if (pop) rptr_d = rptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wptr_q]    <= resp_pc_q;
      instr_mem_q[wptr_q] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(imem_rvalid_i && (outst_q == '0)));
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (instr_ready_i && !instr_valid_o && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (redirect_i && (flush_q != '1)) flush_q <= flush_q + 16'd1;
    end
  end

  assign perf_stall_o = stall_q;
  assign perf_flush_o = flush_q;
`endif

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// tb/tb_ifetch_prefetch_unit.sv - randomized bench for ifetch_prefetch_unit
module tb_ifetch_prefetch_unit;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_o;
  logic [15:0] perf_flush_o;
`endif

  always #5 clk = ~clk;

  ifetch_prefetch_unit #(
    .XLEN(32), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o)
`ifdef IFETCH_PERF_EN
    , .perf_stall_o(perf_stall_o), .perf_flush_o(perf_flush_o)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } rd_t;

  int          errors = 0;
  int          checks = 0;
  rd_t         pend[$];
  logic [31:0] fifo_pc[$];
  logic [31:0] acc_log[$];
  logic [31:0] m_fpc;
  logic [31:0] m_stall;
  logic [15:0] m_flush;
  int          cyc = 0;
  int          n_grants, n_accepts;
  int          gnt_pct, rdy_pct, rv_pct, redir_pct;
  bit          force_redir = 0;
  logic [31:0] force_pc;
  bit          obs_req, obs_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic set_pct(input int g, input int r, input int v, input int d);
    gnt_pct = g; rdy_pct = r; rv_pct = v; redir_pct = d;
  endtask

  task automatic drive_idle();
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
    redirect_i = 0; redirect_pc_i = '0; instr_ready_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("rst_req", imem_req_o, 0);
      check("rst_valid", instr_valid_o, 0);
      check("rst_pc", pc_o, 0);
      check("rst_instr", instr_o, 0);
`ifdef IFETCH_PERF_EN
      check("rst_perf_stall", perf_stall_o, 0);
      check("rst_perf_flush", {16'h0, perf_flush_o}, 0);
`endif
    end
    pend.delete();
    fifo_pc.delete();
    acc_log.delete();
    m_fpc = 32'h0;
    m_stall = '0;
    m_flush = '0;
    n_grants = 0;
    n_accepts = 0;
    rst = 1'b0;
  endtask

  task automatic step();
    rd_t r;
    bit  exp_req, acc;
    @(negedge clk);
    imem_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
    instr_ready_i = ($urandom_range(0, 99) < rdy_pct);
    if (force_redir) begin
      redirect_i = 1'b1; redirect_pc_i = force_pc; force_redir = 0;
    end else begin
      redirect_i = ($urandom_range(0, 99) < redir_pct); redirect_pc_i = $urandom;
    end
    if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 99) < rv_pct) begin
      imem_rvalid_i = 1'b1; imem_rdata_i = memfn(pend[0].addr);
    end else begin
      imem_rvalid_i = 1'b0; imem_rdata_i = $urandom;
    end
    #1;
    exp_req = !redirect_i && (fifo_pc.size() + pend.size() < DEPTH) && (pend.size() < MAX_OUTST);
    obs_req = imem_req_o;
    obs_valid = instr_valid_o;
    check("req", imem_req_o, exp_req);
    if (exp_req) check("addr", imem_addr_o, m_fpc);
    check("valid", instr_valid_o, fifo_pc.size() != 0);
    if (fifo_pc.size() != 0) begin
      check("pc", pc_o, fifo_pc[0]);
      check("instr", instr_o, memfn(fifo_pc[0]));
    end else begin
      check("pc_idle", pc_o, 0);
      check("instr_idle", instr_o, 0);
    end
`ifdef IFETCH_PERF_EN
    check("perf_stall", perf_stall_o, m_stall);
    check("perf_flush", {16'h0, perf_flush_o}, {16'h0, m_flush});
`endif
    @(posedge clk);
    acc = (fifo_pc.size() != 0) && instr_ready_i;
    if (instr_ready_i && fifo_pc.size() == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (redirect_i && m_flush != 16'hFFFF) m_flush++;
    if (acc) begin
      n_accepts++;
      acc_log.push_back(fifo_pc[0]);
    end
    if (redirect_i) begin
      fifo_pc.delete();
      acc_log.delete();
      if (imem_rvalid_i) r = pend.pop_front();
      foreach (pend[i]) pend[i].stale = 1;
      m_fpc = redirect_pc_i & ~32'h3;
    end else begin
      if (acc) void'(fifo_pc.pop_front());
      if (imem_rvalid_i) begin
        r = pend.pop_front();
        if (!r.stale) fifo_pc.push_back(r.addr);
      end
      if (exp_req && imem_gnt_i) begin
        pend.push_back('{addr: m_fpc, stale: 1'b0, due: cyc + 1});
        m_fpc += 32'd4;
        n_grants++;
      end
    end
    cyc++;
  endtask

  initial begin
    int first;
    rst = 1'b1;
    drive_idle();

    // Continuous grant/ready with 1-cycle memory: one instruction per cycle from PC 0.
    set_pct(100, 100, 100, 0);
    do_reset();
    first = -1;
    for (int i = 0; i < 22; i++) begin
      step();
      if (obs_valid && first < 0) first = i;
    end
    check("t1_first_valid", (first >= 0 && first <= 3), 1);
    check("t1_accepts", n_accepts, 20);
    check("t1_first_pc", log_at(0), 32'h0);

    // Backpressure: FIFO fills with exactly DEPTH reads, then drains in order.
    set_pct(100, 0, 100, 0);
    do_reset();
    repeat (20) step();
    check("t2_grants", n_grants, DEPTH);
    check("t2_req_low", obs_req, 0);
    check("t2_valid", obs_valid, 1);
    rdy_pct = 100;
    repeat (10) step();
    for (int i = 0; i < 4; i++) check("t2_order", log_at(i), 32'(i * 4));
    check("t2_accepts", n_accepts >= 8, 1);

    // Redirect to an unaligned PC with two reads outstanding.
    set_pct(100, 100, 0, 0);
    do_reset();
    repeat (3) step();
    check("t3_outst_block", obs_req, 0);
    force_redir = 1; force_pc = 32'h43;
    step();
    rv_pct = 100;
    repeat (10) step();
    check("t3_first_pc", log_at(0), 32'h40);

    // PC wrap across 2^32.
    force_redir = 1; force_pc = 32'hFFFF_FFF8;
    step();
    repeat (10) step();
    check("t4_wrap0", log_at(0), 32'hFFFF_FFF8);
    check("t4_wrap1", log_at(1), 32'hFFFF_FFFC);
    check("t4_wrap2", log_at(2), 32'h0000_0000);

    // Redirect coinciding with rvalid, then a second redirect the next cycle.
    set_pct(100, 100, 100, 0);
    do_reset();
    repeat (4) step();
    force_redir = 1; force_pc = 32'h200;
    step();
    force_redir = 1; force_pc = 32'h80;
    step();
    repeat (10) step();
    check("t5_first_pc", log_at(0), 32'h80);

`ifdef IFETCH_PERF_EN
    set_pct(0, 100, 0, 0);
    do_reset();
    repeat (5) step();
    rdy_pct = 0;
    for (int i = 0; i < 3; i++) begin
      force_redir = 1; force_pc = 32'(i * 16);
      step();
    end
    #1;
    check("t6_stall", perf_stall_o, 5);
    check("t6_flush", {16'h0, perf_flush_o}, 3);
    do_reset();
    #1;
    check("t6_stall_clr", perf_stall_o, 0);
    check("t6_flush_clr", {16'h0, perf_flush_o}, 0);
`endif

    // Randomized traffic with occasional redirects and a mid-stream reset.
    for (int blk = 0; blk < 4; blk++) begin
      set_pct($urandom_range(40, 100), $urandom_range(30, 100),
              $urandom_range(30, 100), $urandom_range(1, 8));
      repeat (1500) step();
      if (blk == 1) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
